// File: rtl/dpram_pkg.sv
// Shared constants and address-mapping helpers for the banked dual-port RAM.
package dpram_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int BYTE_BITS = 8;

    // Number of byte lanes in a data word.
    function automatic int unsigned lanes_of(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    // Bank index: low address bits when interleaved, high bits otherwise.
    function automatic int unsigned bank_of(input int unsigned addr,
                                            input int unsigned bank_bits,
                                            input int unsigned addr_width,
                                            input bit          interleave);
        if (interleave)
            return addr & ((32'd1 << bank_bits) - 32'd1);
        return addr >> (addr_width - bank_bits);
    endfunction

    // Word address inside the selected bank (the bank bits stripped off).
    function automatic int unsigned local_addr(input int unsigned addr,
                                               input int unsigned bank_bits,
                                               input int unsigned addr_width,
                                               input bit          interleave);
        if (interleave)
            return addr >> bank_bits;
        return addr & ((32'd1 << (addr_width - bank_bits)) - 32'd1);
    endfunction

endpackage

// File: rtl/dpram_bank.sv
// Single-port RAM bank: byte-enable writes, read-first, one-cycle registered read.
module dpram_bank
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 8
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [DEPTH_BITS-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [lanes_of(DATA_WIDTH)-1:0] be,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int LANES = lanes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_BITS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage and read register carry no reset; the top level qualifies rdata with rvalid.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i])
                        mem_q[addr][i*BYTE_BITS +: BYTE_BITS] <= wdata[i*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dpram_banked_arb.sv
// Two-port front end over NUM_BANKS single-port banks with per-bank conflict arbitration.
module dpram_banked_arb
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int INTERLEAVE = 1,
    parameter int ARB_MODE   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    output logic                    a_gnt,
    output logic                    a_rvalid,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    output logic                    b_gnt,
    output logic                    b_rvalid,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic [CNT_WIDTH-1:0]    conflict_cnt
);

    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int LOCAL_BITS = ADDR_WIDTH - BANK_BITS;
    localparam bit ILV        = (INTERLEAVE != 0);

    logic [BANK_BITS-1:0]  bank_a, bank_b;
    logic [LOCAL_BITS-1:0] local_a, local_b;
    logic                  conflict, a_wins;

    logic                  rr_q, rr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [BANK_BITS-1:0]  a_bsel_q, a_bsel_d, b_bsel_q, b_bsel_d;
    logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;

    logic [NUM_BANKS-1:0]    a_hit, b_hit, bank_en, bank_we;
    logic [LOCAL_BITS-1:0]   bank_addr  [NUM_BANKS];
    logic [DATA_WIDTH-1:0]   bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH/8-1:0] bank_be    [NUM_BANKS];
    logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];

    // Address decode and arbitration; rr_q=0 means A is preferred on the next conflict.
    always_comb begin
        bank_a   = BANK_BITS'(bank_of(32'(a_addr), BANK_BITS, ADDR_WIDTH, ILV));
        bank_b   = BANK_BITS'(bank_of(32'(b_addr), BANK_BITS, ADDR_WIDTH, ILV));
        local_a  = LOCAL_BITS'(local_addr(32'(a_addr), BANK_BITS, ADDR_WIDTH, ILV));
        local_b  = LOCAL_BITS'(local_addr(32'(b_addr), BANK_BITS, ADDR_WIDTH, ILV));
        conflict = a_req && b_req && (bank_a == bank_b);
        a_wins   = (ARB_MODE == ARB_FIXED) ? 1'b1 : !rr_q;
        a_gnt    = a_req && (!conflict || a_wins);
        b_gnt    = b_req && (!conflict || !a_wins);
    end

    // Per-bank request steering; arbitration guarantees at most one port hits a bank.
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        assign a_hit[k]      = a_gnt && (bank_a == BANK_BITS'(k));
        assign b_hit[k]      = b_gnt && (bank_b == BANK_BITS'(k));
        assign bank_en[k]    = a_hit[k] || b_hit[k];
        assign bank_we[k]    = a_hit[k] ? a_we    : b_we;
        assign bank_addr[k]  = a_hit[k] ? local_a : local_b;
        assign bank_wdata[k] = a_hit[k] ? a_wdata : b_wdata;
        assign bank_be[k]    = a_hit[k] ? a_be    : b_be;

        dpram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH_BITS (LOCAL_BITS)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[k]),
            .we    (bank_we[k]),
            .addr  (bank_addr[k]),
            .wdata (bank_wdata[k]),
            .be    (bank_be[k]),
            .rdata (bank_rdata[k])
        );
    end

    // Next-state for pointer, counter and read pipelines; rdata falls back to the held word.
    always_comb begin
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        if (conflict) begin
            if (ARB_MODE == ARB_RR)
                rr_d = !rr_q;
            if (cnt_q != {CNT_WIDTH{1'b1}})
                cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        a_rvalid_d = a_gnt && !a_we;
        b_rvalid_d = b_gnt && !b_we;
        a_bsel_d   = a_gnt ? bank_a : a_bsel_q;
        b_bsel_d   = b_gnt ? bank_b : b_bsel_q;
        a_rdata    = a_rvalid_q ? bank_rdata[a_bsel_q] : a_hold_q;
        b_rdata    = b_rvalid_q ? bank_rdata[b_bsel_q] : b_hold_q;
        a_hold_d   = a_rdata;
        b_hold_d   = b_rdata;
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_bsel_q   <= '0;
            b_bsel_q   <= '0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_bsel_q   <= a_bsel_d;
            b_bsel_q   <= b_bsel_d;
            a_hold_q   <= a_hold_d;
            b_hold_q   <= b_hold_d;
        end
    end

    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dpram_banked_arb.sv
// Directed bench: fixed-priority instance for data paths, round-robin instance with a 2-bit counter.
module tb_dpram_banked_arb;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_req, a_we, b_req, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_be, b_be;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [15:0] conflict_cnt;

    logic        ra_req, rb_req;
    logic [9:0]  ra_addr, rb_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        ra_gnt, ra_rvalid, rb_gnt, rb_rvalid;
    logic [31:0] ra_rdata, rb_rdata;
    logic [1:0]  r_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpram_banked_arb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_BANKS(4),
        .INTERLEAVE(1), .ARB_MODE(0), .CNT_WIDTH(16)
    ) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .conflict_cnt(conflict_cnt)
    );

    dpram_banked_arb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_BANKS(4),
        .INTERLEAVE(1), .ARB_MODE(1), .CNT_WIDTH(2)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .a_req(ra_req), .a_we(r_we), .a_addr(ra_addr), .a_wdata(r_wdata), .a_be(r_be),
        .a_gnt(ra_gnt), .a_rvalid(ra_rvalid), .a_rdata(ra_rdata),
        .b_req(rb_req), .b_we(r_we), .b_addr(rb_addr), .b_wdata(r_wdata), .b_be(r_be),
        .b_gnt(rb_gnt), .b_rvalid(rb_rvalid), .b_rdata(rb_rdata),
        .conflict_cnt(r_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master rule on the fixed instance: a stalled request must be held unchanged.
    logic        a_pend, b_pend;
    logic [78:0] a_snap, b_snap;
    always @(posedge clk) begin
        if (rst_n && a_pend) begin
            total++;
            assert ({a_req, a_we, a_addr, a_wdata, a_be} === a_snap) else begin
                bad++;
                $error("FAIL a_hold observed=%h expected=%h", {a_req, a_we, a_addr, a_wdata, a_be}, a_snap);
            end
        end
        if (rst_n && b_pend) begin
            total++;
            assert ({b_req, b_we, b_addr, b_wdata, b_be} === b_snap) else begin
                bad++;
                $error("FAIL b_hold observed=%h expected=%h", {b_req, b_we, b_addr, b_wdata, b_be}, b_snap);
            end
        end
        a_pend <= rst_n && a_req && !a_gnt;
        b_pend <= rst_n && b_req && !b_gnt;
        a_snap <= {a_req, a_we, a_addr, a_wdata, a_be};
        b_snap <= {b_req, b_we, b_addr, b_wdata, b_be};
    end

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
        ra_req = 0; rb_req = 0; ra_addr = '0; rb_addr = '0;
        r_we = 0; r_wdata = '0; r_be = '0;
        a_pend = 0; b_pend = 0; a_snap = '0; b_snap = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_a_gnt", 32'(a_gnt), 32'd0);
        chk("idle_b_gnt", 32'(b_gnt), 32'd0);

        // Parallel writes to different banks, then cross reads
        a_req = 1; a_we = 1; a_addr = 10'h004; a_wdata = 32'hDEADBEEF; a_be = 4'hF;
        b_req = 1; b_we = 1; b_addr = 10'h005; b_wdata = 32'h12345678; b_be = 4'hF;
        #1;
        chk("wr_a_gnt", 32'(a_gnt), 32'd1);
        chk("wr_b_gnt", 32'(b_gnt), 32'd1);
        tick();
        chk("wr_a_no_rvalid", 32'(a_rvalid), 32'd0);
        chk("wr_b_no_rvalid", 32'(b_rvalid), 32'd0);
        a_we = 0; a_addr = 10'h005;
        b_we = 0; b_addr = 10'h004;
        #1;
        chk("rd_a_gnt", 32'(a_gnt), 32'd1);
        chk("rd_b_gnt", 32'(b_gnt), 32'd1);
        tick();
        chk("rd_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("rd_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("rd_a_rdata", a_rdata, 32'h12345678);
        chk("rd_b_rdata", b_rdata, 32'hDEADBEEF);
        a_req = 0; b_req = 0;
        tick();
        chk("rd_a_rvalid_pulse", 32'(a_rvalid), 32'd0);
        chk("rd_a_rdata_hold", a_rdata, 32'h12345678);
        chk("rd_b_rdata_hold", b_rdata, 32'hDEADBEEF);

        // Fixed priority conflict on bank 0
        a_req = 1; a_we = 0; a_addr = 10'h008;
        b_req = 1; b_we = 0; b_addr = 10'h00C;
        #1;
        chk("fx_c0_a_gnt", 32'(a_gnt), 32'd1);
        chk("fx_c0_b_gnt", 32'(b_gnt), 32'd0);
        tick();
        chk("fx_c0_cnt", 32'(conflict_cnt), 32'd1);
        chk("fx_c1_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("fx_c1_b_rvalid", 32'(b_rvalid), 32'd0);
        a_req = 0;
        #1;
        chk("fx_c1_b_gnt", 32'(b_gnt), 32'd1);
        tick();
        chk("fx_c2_b_rvalid", 32'(b_rvalid), 32'd1);
        chk("fx_c2_cnt", 32'(conflict_cnt), 32'd1);
        b_req = 0;
        tick();
        chk("fx_c3_b_rvalid", 32'(b_rvalid), 32'd0);

        // Round-robin conflicts: winners A, B, A, then counter saturation
        ra_req = 1; ra_addr = 10'h020;
        rb_req = 1; rb_addr = 10'h030;
        #1;
        chk("rr0_a_gnt", 32'(ra_gnt), 32'd1);
        chk("rr0_b_gnt", 32'(rb_gnt), 32'd0);
        tick();
        ra_addr = 10'h040;
        #1;
        chk("rr1_a_gnt", 32'(ra_gnt), 32'd0);
        chk("rr1_b_gnt", 32'(rb_gnt), 32'd1);
        tick();
        rb_addr = 10'h050;
        #1;
        chk("rr2_a_gnt", 32'(ra_gnt), 32'd1);
        chk("rr2_b_gnt", 32'(rb_gnt), 32'd0);
        tick();
        ra_req = 0; rb_req = 0;
        chk("rr_cnt3", 32'(r_cnt), 32'd3);
        ra_req = 1; ra_addr = 10'h060;
        rb_req = 1; rb_addr = 10'h070;
        #1;
        chk("rr3_b_gnt", 32'(rb_gnt), 32'd1);
        tick();
        ra_req = 0; rb_req = 0;
        chk("rr_cnt_sat", 32'(r_cnt), 32'd3);

        // Byte enables: preload zero, partial write, empty write
        a_req = 1; a_we = 1; a_addr = 10'h010; a_wdata = 32'h00000000; a_be = 4'hF;
        tick();
        a_wdata = 32'hAABBCCDD; a_be = 4'b0101;
        tick();
        a_wdata = 32'hFFFFFFFF; a_be = 4'b0000;
        #1;
        chk("be0_gnt", 32'(a_gnt), 32'd1);
        tick();
        a_we = 0;
        tick();
        a_req = 0;
        chk("be_rvalid", 32'(a_rvalid), 32'd1);
        chk("be_rdata", a_rdata, 32'h00BB00DD);

        // Reset pulse with a read in flight
        a_req = 1; a_we = 0; a_addr = 10'h010;
        tick();
        a_req = 0;
        chk("inflight_rvalid", 32'(a_rvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("mrst_a_rdata", a_rdata, 32'd0);
        chk("mrst_cnt", 32'(conflict_cnt), 32'd0);
        chk("mrst_rr_cnt", 32'(r_cnt), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_rvalid", 32'(a_rvalid), 32'd0);
        a_req = 1; a_we = 0; a_addr = 10'h010;
        tick();
        a_req = 0;
        chk("post_rst_rd_rvalid", 32'(a_rvalid), 32'd1);
        chk("post_rst_rd_rdata", a_rdata, 32'h00BB00DD);
        tick();
        chk("post_rst_rd_pulse", 32'(a_rvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
